// File: rtl/q5_seq_driver.sv
// Bring-up driver for the Q5 two-input sequential machine: resets it, plays the
// fixed 8-step X1/X2 sequence and scores the sampled Z1/Z2 against the golden table.
module q5_seq_driver #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       z1,
  input  logic       z2,
  output logic       x1,
  output logic       x2,
  output logic       dut_rst,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       err_valid,
  output logic [2:0] first_err_idx,
  output logic [2:0] vec_idx
);

  typedef enum logic [2:0] {IDLE, MRST, APPLY, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] settle_cnt;
  logic       mismatch;

  function automatic logic [1:0] vec_x(input logic [2:0] i);
    case (i)
      3'd0: vec_x = 2'b00;
      3'd1: vec_x = 2'b01;
      3'd2: vec_x = 2'b11;
      3'd3: vec_x = 2'b01;
      3'd4: vec_x = 2'b00;
      3'd5: vec_x = 2'b10;
      3'd6: vec_x = 2'b11;
      default: vec_x = 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] vec_z(input logic [2:0] i);
    case (i)
      3'd2: vec_z = 2'b11;
      3'd3: vec_z = 2'b10;
      3'd4: vec_z = 2'b10;
      3'd5: vec_z = 2'b01;
      default: vec_z = 2'b00;
    endcase
  endfunction

  // Z is taken straight from the machine at the SAMPLE edge.
  assign mismatch = ({z1, z2} != vec_z(vec_idx));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      x1            <= 1'b0;
      x2            <= 1'b0;
      dut_rst       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      err_valid     <= 1'b0;
      first_err_idx <= '0;
      vec_idx       <= '0;
    end else begin
      dut_rst <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= MRST;
            dut_rst       <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            err_valid     <= 1'b0;
            first_err_idx <= '0;
            vec_idx       <= '0;
            {x1, x2}      <= 2'b00;
          end
        end
        MRST: begin
          state      <= APPLY;
          {x1, x2}   <= vec_x(3'd0);
          settle_cnt <= SETTLE_LOAD;
        end
        APPLY: begin
          if (settle_cnt == 4'd0) state <= SAMPLE;
          else settle_cnt <= settle_cnt - 4'd1;
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 4'd1;
            if (!err_valid) begin
              err_valid     <= 1'b1;
              first_err_idx <= vec_idx;
            end
          end
          if (vec_idx == 3'd7) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            // err_count has not absorbed this step's result yet.
            pass     <= (err_count == 4'd0) && !mismatch;
            {x1, x2} <= 2'b00;
          end else begin
            state      <= APPLY;
            vec_idx    <= vec_idx + 3'd1;
            {x1, x2}   <= vec_x(vec_idx + 3'd1);
            settle_cnt <= SETTLE_LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/q5_seq_driver.md
# q5_seq_driver

- Self-checking stimulus driver for the Q5 two-input sequential machine (inputs X1/X2, outputs Z1/Z2); sits on the opposite side of that machine's interface.
- Resets the machine, then plays the fixed 8-step X1/X2 sequence one step per vector slot.
- Samples Z1/Z2 at the end of each slot, compares against the golden response and reports mismatch count, first failing step and an overall pass flag.
- Used as a synthesizable bring-up checker alongside the behavioural and structural implementations.

## Interface
- SETTLE_CYCLES, default 4: cycles each vector is held before Z is sampled; legal range 1..15.
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset of this block.
- start  input  1  run request; sampled only in IDLE or DONE.
- z1  input  1  machine output Z1.
- z2  input  1  machine output Z2.
- x1  output  1  machine input X1 (registered).
- x2  output  1  machine input X2 (registered).
- dut_rst  output  1  one-cycle registered reset pulse to the machine at run start.
- busy  output  1  high from start acceptance until DONE is entered.
- done  output  1  high in DONE; held until the next accepted start or rst.
- pass  output  1  valid with done; 1 iff err_count == 0.
- err_count  output  4  number of mismatching steps in the current/last run (0..8, no wrap).
- err_valid  output  1  at least one mismatch recorded this run.
- first_err_idx  output  3  index of first mismatching step; meaningful only when err_valid = 1.
- vec_idx  output  3  index of the vector currently driven.

## Operation
- Vector table, index: X1X2 -> expected Z1Z2:
  - 0: 00 -> 00
  - 1: 01 -> 00
  - 2: 11 -> 11
  - 3: 01 -> 10
  - 4: 00 -> 10
  - 5: 10 -> 01
  - 6: 11 -> 00
  - 7: 01 -> 00
- States:
  - IDLE
  - MRST: dut_rst = 1, x = 00
  - APPLY: x = table[vec_idx], settle counter running
  - SAMPLE
  - DONE
- Transitions:
  - IDLE/DONE -> MRST on start = 1. Clears err_count, err_valid, first_err_idx, vec_idx, done, pass; sets busy.
  - MRST -> APPLY after exactly 1 cycle; x loaded with vector 0; settle counter loaded with SETTLE_CYCLES-1.
  - APPLY -> SAMPLE when the settle counter reaches 0.
  - SAMPLE action: compare {z1,z2} to the expected value. On mismatch, err_count += 1; if err_valid was 0, set err_valid and first_err_idx = vec_idx.
  - SAMPLE -> APPLY with vec_idx + 1 and the new x, if vec_idx != 7.
  - SAMPLE -> DONE if vec_idx == 7: busy = 0, done = 1, pass = (final err_count == 0), x = 00.
- In IDLE and DONE, x1 = x2 = 0 and dut_rst = 0.
- start = 1 while busy is ignored: no restart, no count change.
- The Z comparison uses the combinational z values present at the SAMPLE clock edge. The machine's Z must be settled within SETTLE_CYCLES cycles of an x change.

## Timing
- Reset values, all outputs: x1 = 0, x2 = 0, dut_rst = 0, busy = 0, done = 0, pass = 0, err_count = 0, err_valid = 0, first_err_idx = 0, vec_idx = 0. State = IDLE.
- Reset mid-run: all state returns to the reset values immediately, independent of clk; x drops to 00 and the run is abandoned. A new start is required.
- Start is accepted on the edge where start = 1 in IDLE/DONE.
- dut_rst is high for the 1 cycle following acceptance.
- Each vector occupies exactly SETTLE_CYCLES + 1 cycles: SETTLE_CYCLES in APPLY, 1 in SAMPLE. x is constant across the whole slot.
- Total run length, from the acceptance edge to the done = 1 edge: 1 + 8*(SETTLE_CYCLES+1) cycles. This is 41 for the default, 17 for SETTLE_CYCLES = 1.
- start and rst asserted together: rst wins.
- start held high through DONE: the run is re-accepted on the first DONE cycle, so done is high for 1 cycle only.

## Test plan
- Bench model returns the expected Z for each vec_idx -> done after 41 cycles, pass = 1, err_count = 0, err_valid = 0.
- z1 = z2 = 0 tied -> mismatches at steps 2, 3, 4, 5: err_count = 4, first_err_idx = 2, err_valid = 1, pass = 0.
- z1 = z2 = 1 tied -> mismatches at all steps except 2: err_count = 7, first_err_idx = 0, pass = 0.
- rst pulsed while vec_idx = 3, then start issued -> outputs at reset values with x = 00 during reset. The new run begins with the dut_rst pulse, and counters start from 0.
- start pulsed mid-run at vec_idx = 5 -> ignored; run completes in 41 cycles with the counts unchanged. A second start from DONE clears done/pass/err_count on acceptance.
- SETTLE_CYCLES = 1 build, perfect model -> done after 17 cycles, pass = 1. Each x value is held exactly 2 cycles.
